plic_lite: RTL
==============

Name: plic_lite

Overview:
- Platform-level interrupt controller for the riscv_soc. It is the receiving end of the external io0..io3 interrupt lines.
- Converts edge events on those lines into pending bits and arbitrates by priority against a threshold.
- Drives a single machine external interrupt request to the core's CSR/interrupt-control logic.
- Core-side software accesses it through a memory-mapped register port with claim/complete semantics.

Parameters:
- NUM_SRC, 4, number of interrupt sources; io_irq[k] maps to source ID k+1; ID 0 means "none".
- PRIO_W, 3, priority width; priority 0 means never interrupt.
- ID_W, 5, width of claim/complete ID field.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- io_irq  input  NUM_SRC  raw external interrupt lines; rising edge = event
- we_i  input  1  register write strobe
- re_i  input  1  register read strobe
- addr_i  input  12  byte address within the block, word aligned
- wdata_i  input  32  write data
- rdata_o  output  32  read data, valid the cycle after re_i
- irq_o  output  1  machine external interrupt request to the core

Behaviour:
- Reset: all priority, enable, threshold, pending, in_service and edge-history flops = 0; rdata_o = 0; irq_o = 0.
- Register map (word registers; unused bits read 0, writes to them are ignored; unmapped addresses read 0 and ignore writes):
  - 0x000+4*id: priority[id] for id = 1..NUM_SRC, [PRIO_W-1:0]; id 0 reads 0.
  - 0x080: pending, read-only; bit id = pending[id].
  - 0x100: enable; bit id, bit 0 forced 0.
  - 0x200: threshold [PRIO_W-1:0].
  - 0x204: claim on read, complete on write.
- Gateway, per source:
  - Detect rising edge: io_irq high this cycle, low last sampled cycle.
  - On an edge with pending=0 and in_service=0, set pending at the next clk edge.
  - Edges arriving while pending or in_service are dropped; there is no counting.
- Arbitration, combinational:
  - Candidate = pending & enable & (priority > threshold).
  - Winner = highest priority; ties go to the lowest ID. No candidate gives ID 0.
- irq_o is registered: high one cycle after a candidate exists; drops one cycle after none remain.
- Latency, io_irq rise to irq_o: 2 clk edges without the sync macro.
- Claim (re_i at 0x204):
  - rdata_o = winner ID on the next edge.
  - The same edge clears pending[winner] and sets in_service[winner].
  - Claim with winner 0 returns 0 and has no side effect.
- Complete (we_i at 0x204, wdata_i[ID_W-1:0] = id):
  - Clears in_service[id] if it is set.
  - Out-of-range or not-in-service IDs are ignored.
- Simultaneous events:
  - re_i and we_i in the same cycle: both take effect; the read returns pre-write state.
  - Edge in the same cycle as a claim of that source: dropped.
  - Edge in the same cycle as a complete of that source: dropped, because the gate is still closed that cycle.
  - Priority or enable write in the same cycle as a claim: the claim uses the old values.
- Reset mid-operation: all state is cleared immediately and irq_o drops asynchronously.

Optional Feature:
- Macro: PLIC_SYNC_EN.
- Defined: each io_irq passes a 2-flop synchronizer (reset 0) before edge detection, adding 2 cycles of latency (4 edges rise to irq_o).
- Undefined: io_irq is sampled directly, for synchronous testbench and FPGA-internal sources.

Decomposition:
- Shared package plic_pkg:
  - register offsets PLIC_PRIO_BASE, PLIC_PENDING, PLIC_ENABLE, PLIC_THRESHOLD, PLIC_CLAIM;
  - NUM_SRC, PRIO_W, ID_W defaults;
  - ID_NONE = 0.
- One sub-module, plic_gateway: per source, contains sync (optional), edge detect, pending and in_service flops, with claim/complete inputs. Generated NUM_SRC times.
- Arbitration tree and register decode stay in plic_lite.

Test Plan:
1. Set priority[2]=1, priority[3]=3, enable=0x0C, threshold=0. Pulse io1 and io2 high for 1 cycle together → pending=0x0C, irq_o=1 two edges after the rise; claim reads 3; next claim reads 2; then irq_o=0.
2. Set priority[2]=priority[3]=2 and pulse both → claim returns 2 (lowest ID wins the tie).
3. Set threshold=3, priority[2]=3, pulse io1 → pending[2]=1, irq_o stays 0; write threshold=2 → irq_o=1 next edge.
4. After claiming ID 2, pulse io1 again → dropped, pending stays 0. Write complete=2, then pulse io1 → pending[2]=1.
5. Write complete=4 while source 4 is not in service → no state change. Claim with nothing pending → reads 0.
6. Assert rst mid-claim → irq_o, rdata_o, pending and enable all 0 immediately. With PLIC_SYNC_EN defined, rerun scenario 1 → irq_o rises 4 edges after the io rise.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared constants for plic_lite: default sizing, register offsets and the null ID.
package plic_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned PRIO_W  = 3;
  localparam int unsigned ID_W    = 5;

  localparam int unsigned ID_NONE = 0;

  localparam logic [11:0] PLIC_PRIO_BASE = 12'h000;
  localparam logic [11:0] PLIC_PENDING   = 12'h080;
  localparam logic [11:0] PLIC_ENABLE    = 12'h100;
  localparam logic [11:0] PLIC_THRESHOLD = 12'h200;
  localparam logic [11:0] PLIC_CLAIM     = 12'h204;

endpackage

// File: rtl/plic_lite_if.sv
// Register access port of plic_lite: strobes, address and data in both directions.
interface plic_lite_if;

  logic        we_i;
  logic        re_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output we_i, re_i, addr_i, wdata_i, input rdata_o);
  modport slave  (input we_i, re_i, addr_i, wdata_i, output rdata_o);

endinterface

// File: rtl/plic_gateway.sv
// One interrupt source gateway: optional 2-flop sync (PLIC_SYNC_EN), rising-edge
// detect, and the pending / in_service flops that gate further events.
module plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);

  logic w_irq;
  logic w_edge;
  logic r_prev;
  logic r_pending;
  logic r_in_service;

`ifdef PLIC_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_irq};
  end

  assign w_irq = r_sync[1];
`else
  assign w_irq = i_irq;
`endif

  assign w_edge = w_irq & ~r_prev;

  // The gate uses the current-cycle flops, so an edge coinciding with a claim or
  // a complete of this source sees the gate closed and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= 1'b0;
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_prev <= w_irq;
      if (i_claim)
        r_pending <= 1'b0;
      else if (w_edge && !r_pending && !r_in_service)
        r_pending <= 1'b1;
      if (i_claim)
        r_in_service <= 1'b1;
      else if (i_complete)
        r_in_service <= 1'b0;
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/plic_lite.sv
// Platform-level interrupt controller: per-source gateways, priority/threshold
// arbitration and a claim/complete register port. Optional macro: PLIC_SYNC_EN.
module plic_lite #(
  parameter int unsigned NUM_SRC = plic_pkg::NUM_SRC,
  parameter int unsigned PRIO_W  = plic_pkg::PRIO_W,
  parameter int unsigned ID_W    = plic_pkg::ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] io_irq,
  plic_lite_if.slave         bus,
  output logic               irq_o
);

  import plic_pkg::*;

  logic [PRIO_W-1:0] r_prio [1:NUM_SRC];
  logic [NUM_SRC:1]  r_enable;
  logic [PRIO_W-1:0] r_threshold;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic [NUM_SRC:1]  w_pending;
  logic [NUM_SRC:1]  w_in_service;
  logic [NUM_SRC:1]  w_claim_vec;
  logic [NUM_SRC:1]  w_complete_vec;
  logic [ID_W-1:0]   w_winner;
  logic [PRIO_W-1:0] w_best;
  logic [31:0]       w_rdata;
  logic              w_rd_claim;
  logic              w_wr_claim;
  logic              w_unused;

  assign w_rd_claim = bus.re_i && (bus.addr_i == PLIC_CLAIM);
  assign w_wr_claim = bus.we_i && (bus.addr_i == PLIC_CLAIM);
  assign w_unused   = &{1'b0, bus.wdata_i, w_in_service};

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk          (clk),
      .rst          (rst),
      .i_irq        (io_irq[g-1]),
      .i_claim      (w_claim_vec[g]),
      .i_complete   (w_complete_vec[g]),
      .o_pending    (w_pending[g]),
      .o_in_service (w_in_service[g])
    );
  end

  // Seeding the running best with the threshold folds the threshold compare into
  // the search; strict '>' keeps the lowest ID on a tie.
  always_comb begin
    w_winner = ID_W'(ID_NONE);
    w_best   = r_threshold;
    for (int unsigned id = 1; id <= NUM_SRC; id++) begin
      if (w_pending[id] && r_enable[id] && (r_prio[id] > w_best)) begin
        w_best   = r_prio[id];
        w_winner = ID_W'(id);
      end
    end
  end

  always_comb begin
    w_claim_vec    = '0;
    w_complete_vec = '0;
    for (int unsigned id = 1; id <= NUM_SRC; id++) begin
      w_claim_vec[id]    = w_rd_claim && (w_winner == ID_W'(id));
      w_complete_vec[id] = w_wr_claim && (bus.wdata_i[ID_W-1:0] == ID_W'(id));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.addr_i)
      PLIC_PENDING: begin
        for (int unsigned id = 1; id <= NUM_SRC; id++) w_rdata[id] = w_pending[id];
      end
      PLIC_ENABLE: begin
        for (int unsigned id = 1; id <= NUM_SRC; id++) w_rdata[id] = r_enable[id];
      end
      PLIC_THRESHOLD: w_rdata[PRIO_W-1:0] = r_threshold;
      PLIC_CLAIM:     w_rdata[ID_W-1:0]   = w_winner;
      default: begin
        for (int unsigned id = 1; id <= NUM_SRC; id++) begin
          if (bus.addr_i == PLIC_PRIO_BASE + 12'(4 * id))
            w_rdata[PRIO_W-1:0] = r_prio[id];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned id = 1; id <= NUM_SRC; id++) r_prio[id] <= '0;
      r_enable    <= '0;
      r_threshold <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq   <= (w_winner != ID_W'(ID_NONE));
      r_rdata <= bus.re_i ? w_rdata : '0;
      if (bus.we_i) begin
        case (bus.addr_i)
          PLIC_ENABLE:    r_enable    <= bus.wdata_i[NUM_SRC:1];
          PLIC_THRESHOLD: r_threshold <= bus.wdata_i[PRIO_W-1:0];
          default: begin
            for (int unsigned id = 1; id <= NUM_SRC; id++) begin
              if (bus.addr_i == PLIC_PRIO_BASE + 12'(4 * id))
                r_prio[id] <= bus.wdata_i[PRIO_W-1:0];
            end
          end
        endcase
      end
    end
  end

  assign bus.rdata_o = r_rdata;
  assign irq_o       = r_irq;

endmodule
